// File: rtl/eddr_host_client.sv
// Ethernet-encapsulated memory client: one load/store request at a time is framed onto
// the tx beat stream, and the matching reply (or a timeout) completes it.
//   state | meaning
//   IDLE  | ready for a user request
//   TX    | sending request frame beats
//   WAIT  | awaiting first reply beat
//   RX    | receiving reply frame beats
module eddr_host_client #(
    parameter logic [47:0] MAC_DST  = 48'hffff_ffff_ffff,
    parameter logic [47:0] MAC_SRC  = 48'h0102_0304_0506,
    parameter logic [15:0] ETH_TYPE = 16'h8888,
    parameter logic [15:0] TIMEOUT  = 16'hffff
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_val,
    output logic         req_rdy,
    input  logic         req_rw,
    input  logic [25:0]  req_addr,
    input  logic [255:0] req_data,
    output logic         resp_val,
    output logic         resp_err,
    output logic [255:0] resp_data,
    output logic [63:0]  txq_bits,
    output logic [7:0]   txq_aux_bits,
    output logic         txq_val,
    input  logic         txq_rdy,
    input  logic [63:0]  rxq_bits,
    input  logic [7:0]   rxq_aux_bits,
    input  logic         rxq_val,
    output logic         rxq_rdy
);

    typedef enum logic [1:0] {IDLE, TX, WAIT, RX} state_t;

    state_t         state;
    logic [2:0]     tx_cnt;
    logic [2:0]     rx_cnt;
    logic [15:0]    to_cnt;
    logic           rw_q;
    logic [25:0]    addr_q;
    logic [255:0]   data_q;
    logic [191:0]   rx_buf;
    logic [2:0]     last_beat;
    logic           type_ok;
    logic           rx_done;
    logic           timed_out;
    logic           unused_rx_aux;

    assign unused_rx_aux = ^rxq_aux_bits;

    assign req_rdy   = (state == IDLE) && reset_n;
    assign txq_val   = (state == TX);
    assign rxq_rdy   = (state == WAIT) || (state == RX);
    assign last_beat = rw_q ? 3'd7 : 3'd3;
    assign type_ok   = (rxq_bits[47:32] == ETH_TYPE);
    assign rx_done   = rxq_val && (state == RX) &&
                       (((rx_cnt == 3'd1) && type_ok && rw_q) || (rx_cnt == 3'd5));
    assign timed_out = rxq_rdy && ((to_cnt + 16'd1) == TIMEOUT);

    always_comb begin
        txq_bits     = 64'h0;
        txq_aux_bits = 8'h00;
        if (state == TX) begin
            txq_aux_bits = (tx_cnt == last_beat) ? 8'h47 : 8'h07;
            case (tx_cnt)
                3'd0:    txq_bits = {MAC_SRC[15:0], MAC_DST};
                3'd1:    txq_bits = {16'h0, ETH_TYPE, MAC_SRC[47:16]};
                3'd2:    txq_bits = {1'b0, addr_q, 5'b0, 31'h0, rw_q};
                3'd3:    txq_bits = rw_q ? data_q[63:0] : 64'h0;
                3'd4:    txq_bits = data_q[127:64];
                3'd5:    txq_bits = data_q[191:128];
                3'd6:    txq_bits = data_q[255:192];
                default: txq_bits = 64'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tx_cnt    <= 3'd0;
            rx_cnt    <= 3'd0;
            to_cnt    <= 16'd0;
            rw_q      <= 1'b0;
            addr_q    <= 26'd0;
            data_q    <= 256'd0;
            rx_buf    <= 192'd0;
            resp_val  <= 1'b0;
            resp_err  <= 1'b0;
            resp_data <= 256'd0;
        end else begin
            resp_val <= 1'b0;
            resp_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_val) begin
                        rw_q   <= req_rw;
                        addr_q <= req_addr;
                        data_q <= req_data;
                        tx_cnt <= 3'd0;
                        state  <= TX;
                    end
                end
                TX: begin
                    if (txq_rdy) begin
                        if (tx_cnt == last_beat) begin
                            state  <= WAIT;
                            rx_cnt <= 3'd0;
                            to_cnt <= 16'd0;
                        end else begin
                            tx_cnt <= tx_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    to_cnt <= to_cnt + 16'd1;
                    if (rxq_val) begin
                        if (state == WAIT) begin
                            state  <= RX;
                            rx_cnt <= 3'd1;
                        end else if ((rx_cnt == 3'd1) && !type_ok) begin
                            // foreign frame: drop it but keep the timeout running
                            state  <= WAIT;
                            rx_cnt <= 3'd0;
                        end else begin
                            rx_cnt <= rx_cnt + 3'd1;
                            case (rx_cnt)
                                3'd2:    rx_buf[63:0]    <= rxq_bits;
                                3'd3:    rx_buf[127:64]  <= rxq_bits;
                                3'd4:    rx_buf[191:128] <= rxq_bits;
                                default: ;
                            endcase
                        end
                    end
                    // a completion landing on the timeout cycle still counts as success
                    if (rx_done) begin
                        resp_val <= 1'b1;
                        state    <= IDLE;
                        if (!rw_q)
                            resp_data <= {rxq_bits, rx_buf};
                    end else if (timed_out) begin
                        resp_val <= 1'b1;
                        resp_err <= 1'b1;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eddr_host_client.sv
// Directed bench for eddr_host_client: load/store framing, reply filtering,
// timeout, reset abort and idle rx behaviour, with TIMEOUT set to 16.
module tb_eddr_host_client;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_val = 1'b0;
    logic         req_rdy;
    logic         req_rw = 1'b0;
    logic [25:0]  req_addr = '0;
    logic [255:0] req_data = '0;
    logic         resp_val;
    logic         resp_err;
    logic [255:0] resp_data;
    logic [63:0]  txq_bits;
    logic [7:0]   txq_aux_bits;
    logic         txq_val;
    logic         txq_rdy = 1'b0;
    logic [63:0]  rxq_bits = '0;
    logic [7:0]   rxq_aux_bits = '0;
    logic         rxq_val = 1'b0;
    logic         rxq_rdy;

    int n_pass = 0;
    int n_total = 0;
    logic [63:0] tx_beat [8];
    logic [7:0]  tx_aux [8];
    int tx_n;

    localparam logic [63:0] BEAT0 = 64'h0506_ffff_ffff_ffff;
    localparam logic [63:0] BEAT1 = 64'h0000_8888_0102_0304;
    localparam logic [63:0] HDR0  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] HDR1  = 64'h0000_8888_0000_0000;
    localparam logic [63:0] BAD1  = 64'h0000_1234_0000_0000;

    eddr_host_client #(.TIMEOUT(16'd16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_val(req_val), .req_rdy(req_rdy), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data),
        .resp_val(resp_val), .resp_err(resp_err), .resp_data(resp_data),
        .txq_bits(txq_bits), .txq_aux_bits(txq_aux_bits), .txq_val(txq_val), .txq_rdy(txq_rdy),
        .rxq_bits(rxq_bits), .rxq_aux_bits(rxq_aux_bits), .rxq_val(rxq_val), .rxq_rdy(rxq_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue a request at the current negedge and capture handshaken tx beats.
    task automatic do_req(input logic rw, input logic [25:0] a, input logic [255:0] d,
                          input bit toggle);
        int cyc;
        check("req_rdy_before_req", req_rdy, 1);
        req_val = 1'b1; req_rw = rw; req_addr = a; req_data = d;
        @(negedge clk);
        req_val = 1'b0;
        tx_n = 0;
        cyc = 0;
        while (cyc < 40) begin
            txq_rdy = toggle ? cyc[0] : 1'b1;
            if (txq_val && txq_rdy && tx_n < 8) begin
                tx_beat[tx_n] = txq_bits;
                tx_aux[tx_n]  = txq_aux_bits;
                tx_n++;
            end
            @(negedge clk);
            cyc++;
            if (tx_n > 0 && tx_aux[tx_n-1][6]) break;
        end
        txq_rdy = 1'b0;
    endtask

    task automatic send_rx(input logic [63:0] bits);
        rxq_val = 1'b1;
        rxq_bits = bits;
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] sdata;
        logic [255:0] ldata;
        logic [255:0] ldata2;
        bit early;

        sdata  = {64'd4, 64'd3, 64'd2, 64'd1};
        ldata  = {64'hDDDD, 64'hCCCC, 64'hBBBB, 64'hAAAA};
        ldata2 = {64'h8888_0000, 64'h7777_0000, 64'h6666_0000, 64'h5555_0000};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_txq_val", txq_val, 0);
        check("rst_rxq_rdy", rxq_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_resp_data", resp_data, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_rdy", req_rdy, 1);

        // rx traffic while idle is ignored
        for (int i = 0; i < 3; i++) begin
            rxq_val = 1'b1; rxq_bits = HDR1;
            @(negedge clk);
            check("idle_rxq_rdy", rxq_rdy, 0);
            check("idle_resp_val", resp_val, 0);
            check("idle_req_rdy", req_rdy, 1);
        end
        rxq_val = 1'b0;

        // load, addr 1
        do_req(1'b0, 26'h1, '0, 1'b0);
        check("ld_beats", tx_n, 4);
        check("ld_b0", tx_beat[0], BEAT0);
        check("ld_b1", tx_beat[1], BEAT1);
        check("ld_b2", tx_beat[2], 64'h0000_0020_0000_0000);
        check("ld_b3", tx_beat[3], 64'h0);
        check("ld_aux0", tx_aux[0], 8'h07);
        check("ld_aux3", tx_aux[3], 8'h47);
        check("wait_txq_val", txq_val, 0);
        check("wait_txq_bits", txq_bits, 0);
        check("wait_rxq_rdy", rxq_rdy, 1);
        send_rx(HDR0);
        send_rx(HDR1);
        send_rx(64'hAAAA);
        send_rx(64'hBBBB);
        send_rx(64'hCCCC);
        check("ld_no_early_resp", resp_val, 0);
        send_rx(64'hDDDD);
        rxq_val = 1'b0;
        check("ld_resp_val", resp_val, 1);
        check("ld_resp_err", resp_err, 0);
        check("ld_resp_data", resp_data, ldata);
        @(negedge clk);
        check("ld_resp_pulse", resp_val, 0);

        // store with txq_rdy toggling
        do_req(1'b1, 26'h3, sdata, 1'b1);
        check("st_beats", tx_n, 8);
        check("st_b0", tx_beat[0], BEAT0);
        check("st_b1", tx_beat[1], BEAT1);
        check("st_b2", tx_beat[2], 64'h0000_0060_0000_0001);
        check("st_b3", tx_beat[3], 64'd1);
        check("st_b4", tx_beat[4], 64'd2);
        check("st_b5", tx_beat[5], 64'd3);
        check("st_b6", tx_beat[6], 64'd4);
        check("st_b7", tx_beat[7], 64'd0);
        check("st_aux6", tx_aux[6], 8'h07);
        check("st_aux7", tx_aux[7], 8'h47);
        send_rx(HDR0);
        send_rx(HDR1);
        rxq_val = 1'b0;
        check("st_resp_val", resp_val, 1);
        check("st_resp_err", resp_err, 0);
        check("st_resp_data_held", resp_data, ldata);

        // foreign-type frame dropped, then a good reply
        @(negedge clk);
        do_req(1'b0, 26'h5, '0, 1'b0);
        send_rx(HDR0);
        send_rx(BAD1);
        check("bad_no_resp", resp_val, 0);
        check("bad_rxq_rdy", rxq_rdy, 1);
        send_rx(HDR0);
        send_rx(HDR1);
        send_rx(64'h5555_0000);
        send_rx(64'h6666_0000);
        send_rx(64'h7777_0000);
        send_rx(64'h8888_0000);
        rxq_val = 1'b0;
        check("bad_then_good_val", resp_val, 1);
        check("bad_then_good_err", resp_err, 0);
        check("bad_then_good_data", resp_data, ldata2);

        // timeout with no reply
        @(negedge clk);
        do_req(1'b0, 26'h7, '0, 1'b0);
        early = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (resp_val) early = 1'b1;
        end
        check("to_no_early_resp", early, 0);
        @(negedge clk);
        check("to_resp_val", resp_val, 1);
        check("to_resp_err", resp_err, 1);
        check("to_resp_data_held", resp_data, ldata2);
        @(negedge clk);
        check("to_req_rdy_next", req_rdy, 1);
        check("to_resp_pulse", resp_val, 0);

        // reset during store beat 4
        check("rr_req_rdy", req_rdy, 1);
        req_val = 1'b1; req_rw = 1'b1; req_addr = 26'h9; req_data = sdata;
        @(negedge clk);
        req_val = 1'b0;
        txq_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (txq_val && txq_bits == 64'd2) break;
            @(negedge clk);
        end
        check("rr_at_beat4", txq_bits, 64'd2);
        reset_n = 1'b0;
        #1;
        check("rr_txq_val", txq_val, 0);
        check("rr_txq_bits", txq_bits, 0);
        check("rr_req_rdy_low", req_rdy, 0);
        early = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (resp_val || txq_val) early = 1'b1;
        end
        reset_n = 1'b1;
        #1;
        check("rr_req_rdy_release", req_rdy, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_val || txq_val) early = 1'b1;
        end
        check("rr_no_activity", early, 0);
        txq_rdy = 1'b0;
        do_req(1'b0, 26'h1, '0, 1'b0);
        check("rr_new_beats", tx_n, 4);
        check("rr_new_b0", tx_beat[0], BEAT0);
        check("rr_new_b2", tx_beat[2], 64'h0000_0020_0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
